// File: rtl/pipe_pkg.sv
// Shared EXE-stage types: ALU op encodings, datapath widths and the ID/EXE register bundle.
package pipe_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] LINK_REG_DFLT = 5'd31;

  // Only aluc[2:0] selects the op, except that SLL/SRL/SRA also use bit 3.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [3:0]        aluc;
    logic              aluimm;
    logic              shift;
    logic              jal;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rn;
    logic [DATA_W-1:0] pc4;
  } exe_reg_t;

endpackage

// File: rtl/pipe_alu.sv
// Combinational EXE ALU; zero latency. No flow control.
module pipe_alu
  import pipe_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        aluc,
  output logic [DATA_W-1:0] r
);

  logic [DATA_W-1:0] sra_r;

  // Kept as its own assignment so the shift stays arithmetic.
  assign sra_r = $signed(b) >>> a[4:0];

  always_comb begin
    r = a + b;
    case (aluc[2:0])
      ALU_SUB[2:0]: r = a - b;
      ALU_AND[2:0]: r = a & b;
      ALU_OR[2:0]:  r = a | b;
      ALU_XOR[2:0]: r = a ^ b;
      ALU_LUI[2:0]: r = {b[15:0], 16'h0000};
      ALU_SLL[2:0]: if (!aluc[3]) r = b << a[4:0];
      ALU_SRL[2:0]: r = aluc[3] ? sra_r : (b >> a[4:0]);
      default:      r = a + b;
    endcase
  end

endmodule

// File: rtl/pipe_exe_stage.sv
// ID/EXE register + ALU; 1-cycle capture, ealu combinational from the register. estall freezes all
// state, wpcir=0 inserts a bubble. Optional PIPE_PERF_CNT_EN adds load/bubble counters.
module pipe_exe_stage
  import pipe_pkg::*;
#(
  parameter logic [REG_W-1:0]  LINK_REG = LINK_REG_DFLT,
  parameter logic [DATA_W-1:0] LINK_OFS = 32'd4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dwreg,
  input  logic              dm2reg,
  input  logic              dwmem,
  input  logic              daluimm,
  input  logic              dshift,
  input  logic              djal,
  input  logic [3:0]        daluc,
  input  logic [DATA_W-1:0] da,
  input  logic [DATA_W-1:0] db,
  input  logic [DATA_W-1:0] dimm,
  input  logic [DATA_W-1:0] dpc4,
  input  logic [REG_W-1:0]  drn,
  input  logic              wpcir,
  input  logic              estall,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic [REG_W-1:0]  ern,
  output logic [DATA_W-1:0] ealu,
  output logic [DATA_W-1:0] eb,
  output logic              evalid,
  output logic [DATA_W-1:0] perf_insn,
  output logic [DATA_W-1:0] perf_bubble
);

  exe_reg_t          r;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_r;

  // Data fields load even on a bubble; only the control bits are squashed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r <= '0;
    end else if (!estall) begin
      r.valid  <= wpcir;
      r.wreg   <= dwreg  & wpcir;
      r.m2reg  <= dm2reg & wpcir;
      r.wmem   <= dwmem  & wpcir;
      r.jal    <= djal   & wpcir;
      r.aluc   <= daluc;
      r.aluimm <= daluimm;
      r.shift  <= dshift;
      r.a      <= da;
      r.b      <= db;
      r.imm    <= dimm;
      r.rn     <= drn;
      r.pc4    <= dpc4;
    end
  end

  assign alu_a = r.shift  ? {27'b0, r.imm[10:6]} : r.a;
  assign alu_b = r.aluimm ? r.imm : r.b;

  pipe_alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .aluc (r.aluc),
    .r    (alu_r)
  );

  assign ewreg  = r.wreg  & r.valid;
  assign ewmem  = r.wmem  & r.valid;
  assign em2reg = r.m2reg & r.valid;
  assign evalid = r.valid;
  assign ern    = r.jal ? LINK_REG : r.rn;
  assign eb     = r.b;
  assign ealu   = r.jal ? (r.pc4 + LINK_OFS) : alu_r;

`ifdef PIPE_PERF_CNT_EN
  logic [DATA_W-1:0] insn_cnt;
  logic [DATA_W-1:0] bubble_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      insn_cnt   <= '0;
      bubble_cnt <= '0;
    end else if (!estall) begin
      if (wpcir) insn_cnt   <= insn_cnt + 32'd1;
      else       bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_insn   = insn_cnt;
  assign perf_bubble = bubble_cnt;
`else
  assign perf_insn   = '0;
  assign perf_bubble = '0;
`endif

endmodule

// File: tb/tb_pipe_exe_stage.sv
// Directed plus randomized bench for pipe_exe_stage against a behavioural reference model.
module tb_pipe_exe_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal;
  logic [3:0]  daluc;
  logic [31:0] da, db, dimm, dpc4;
  logic [4:0]  drn;
  logic        wpcir, estall;
  logic        ewreg, em2reg, ewmem, evalid;
  logic [4:0]  ern;
  logic [31:0] ealu, eb, perf_insn, perf_bubble;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the instruction the stage currently holds.
  logic        m_valid, m_wreg, m_m2reg, m_wmem, m_jal, m_aluimm, m_shift;
  logic        m_data_known;
  logic [3:0]  m_aluc;
  logic [31:0] m_a, m_b, m_imm, m_pc4;
  logic [4:0]  m_rn;
  logic [31:0] m_insn, m_bub;

  always #5 clock = ~clock;

  pipe_exe_stage dut (
    .clock(clock), .reset(reset),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
    .dshift(dshift), .djal(djal), .daluc(daluc),
    .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .drn(drn),
    .wpcir(wpcir), .estall(estall),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern),
    .ealu(ealu), .eb(eb), .evalid(evalid),
    .perf_insn(perf_insn), .perf_bubble(perf_bubble)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    int          sh;
    logic [63:0] ext;
    sh = int'(x[4:0]);
    if (op == 4'b0011) return y << sh;
    if (op == 4'b0111) return y >> sh;
    if (op == 4'b1111) begin
      ext = {{32{y[31]}}, y} >> sh;
      return ext[31:0];
    end
    case (op[2:0])
      3'b100:  return x - y;
      3'b001:  return x & y;
      3'b101:  return x | y;
      3'b010:  return x ^ y;
      3'b110:  return y * 32'd65536;
      default: return x + y;
    endcase
  endfunction

  function automatic logic [31:0] exp_alu();
    logic [31:0] x, y;
    if (m_jal) return m_pc4 + 32'd4;
    x = m_shift  ? 32'(m_imm[10:6]) : m_a;
    y = m_aluimm ? m_imm : m_b;
    return alu_ref(m_aluc, x, y);
  endfunction

  task automatic model_update();
    if (reset) begin
      {m_valid, m_wreg, m_m2reg, m_wmem, m_jal, m_aluimm, m_shift} = '0;
      m_aluc = '0; m_a = '0; m_b = '0; m_imm = '0; m_pc4 = '0; m_rn = '0;
      m_insn = '0; m_bub = '0; m_data_known = 1'b1;
    end else if (!estall) begin
      if (wpcir) begin
        m_valid = 1'b1; m_wreg = dwreg; m_m2reg = dm2reg; m_wmem = dwmem; m_jal = djal;
        m_aluimm = daluimm; m_shift = dshift; m_aluc = daluc;
        m_a = da; m_b = db; m_imm = dimm; m_pc4 = dpc4; m_rn = drn;
        m_data_known = 1'b1;
        m_insn = m_insn + 32'd1;
      end else begin
        {m_valid, m_wreg, m_m2reg, m_wmem, m_jal} = '0;
        m_data_known = 1'b0;
        m_bub = m_bub + 32'd1;
      end
    end
  endtask

  task automatic check_all();
    chk("evalid", 32'(evalid), 32'(m_valid));
    chk("ewreg",  32'(ewreg),  32'(m_wreg  & m_valid));
    chk("ewmem",  32'(ewmem),  32'(m_wmem  & m_valid));
    chk("em2reg", 32'(em2reg), 32'(m_m2reg & m_valid));
    if (m_data_known) begin
      chk("ern",  32'(ern), m_jal ? 32'd31 : 32'(m_rn));
      chk("ealu", ealu, exp_alu());
      chk("eb",   eb,   m_b);
    end
`ifdef PIPE_PERF_CNT_EN
    chk("perf_insn",   perf_insn,   m_insn);
    chk("perf_bubble", perf_bubble, m_bub);
`else
    chk("perf_insn",   perf_insn,   32'd0);
    chk("perf_bubble", perf_bubble, 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_all();
  endtask

  task automatic clear_inputs();
    reset = 1'b0; wpcir = 1'b1; estall = 1'b0;
    {dwreg, dm2reg, dwmem, daluimm, dshift, djal} = '0;
    daluc = '0; da = '0; db = '0; dimm = '0; dpc4 = '0; drn = '0;
  endtask

  task automatic rand_data();
    {dwreg, dm2reg, dwmem, daluimm, dshift, djal} = 6'($urandom);
    daluc = 4'($urandom);
    da = $urandom; db = $urandom; dimm = $urandom; drn = 5'($urandom);
    dpc4 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
  endtask

  initial begin
    clear_inputs();
    {m_valid, m_wreg, m_m2reg, m_wmem, m_jal, m_aluimm, m_shift, m_data_known} = '0;
    m_aluc = '0; m_a = '0; m_b = '0; m_imm = '0; m_pc4 = '0; m_rn = '0;
    m_insn = '0; m_bub = '0;

    reset = 1'b1;
    tick();
    chk("rst_evalid", 32'(evalid), 32'd0);
    chk("rst_ewreg",  32'(ewreg),  32'd0);
    chk("rst_ern",    32'(ern),    32'd0);
    chk("rst_ealu",   ealu,        32'd0);

    clear_inputs();
    da = 32'd5; db = 32'd7; daluc = 4'b0000; drn = 5'd8; dwreg = 1'b1;
    tick();
    chk("add_ealu", ealu, 32'd12);
    chk("add_ern", 32'(ern), 32'd8);
    chk("add_ewreg", 32'(ewreg), 32'd1);
    chk("add_evalid", 32'(evalid), 32'd1);

    wpcir = 1'b0;
    dwmem = 1'b1; dm2reg = 1'b1;
    tick();
    chk("bub_ewreg", 32'(ewreg), 32'd0);
    chk("bub_ewmem", 32'(ewmem), 32'd0);
    chk("bub_em2reg", 32'(em2reg), 32'd0);
    chk("bub_evalid", 32'(evalid), 32'd0);
    tick();
    chk("bub2_evalid", 32'(evalid), 32'd0);

    clear_inputs();
    da = 32'd3; db = 32'd10; daluc = 4'b0100; dwreg = 1'b1; drn = 5'd9;
    tick();
    chk("sub_ealu", ealu, 32'hFFFF_FFF9);
    for (int i = 0; i < 3; i++) begin
      estall = 1'b1; wpcir = 1'($urandom); rand_data();
      tick();
      chk("hold_ealu", ealu, 32'hFFFF_FFF9);
      chk("hold_ern", 32'(ern), 32'd9);
      chk("hold_evalid", 32'(evalid), 32'd1);
    end
    clear_inputs();
    da = 32'd1; db = 32'd2;
    tick();
    chk("unhold_ealu", ealu, 32'd3);

    clear_inputs();
    djal = 1'b1; dpc4 = 32'h0040_0004; drn = 5'd0; dwreg = 1'b1;
    tick();
    chk("jal_ern", 32'(ern), 32'd31);
    chk("jal_ealu", ealu, 32'h0040_0008);
    chk("jal_ewreg", 32'(ewreg), 32'd1);

    dpc4 = 32'hFFFF_FFFC;
    tick();
    chk("jal_wrap", ealu, 32'd0);

    clear_inputs();
    dshift = 1'b1; dimm = 32'(4 << 6); db = 32'h8000_0000; daluc = 4'b0111;
    tick();
    chk("srl", ealu, 32'h0800_0000);
    daluc = 4'b1111;
    tick();
    chk("sra", ealu, 32'hF800_0000);
    daluc = 4'b0011; db = 32'd1;
    tick();
    chk("sll", ealu, 32'h0000_0010);
    daluc = 4'b1111; dimm = 32'h0000_F83F; db = 32'h8000_0001;
    tick();
    chk("sra0", ealu, 32'h8000_0001);

    clear_inputs();
    daluimm = 1'b1; dimm = 32'h0000_ABCD; daluc = 4'b1110;
    tick();
    chk("lui", ealu, 32'hABCD_0000);

    clear_inputs();
    dwreg = 1'b1;
    tick();
    reset = 1'b1; estall = 1'b1;
    tick();
    chk("rst_stall_evalid", 32'(evalid), 32'd0);
    chk("rst_stall_ewreg", 32'(ewreg), 32'd0);

    for (int i = 0; i < 600; i++) begin
      rand_data();
      reset  = ($urandom_range(0, 59) == 0);
      estall = ($urandom_range(0, 4) == 0);
      wpcir  = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_exe_stage.md
Name: pipe_exe_stage

Overview:
- ID/EXE pipeline register plus EXE-stage ALU.
- Captures the decoded bundle produced by the ID stage and computes ealu.
- Returns ern/ewreg/em2reg/ealu to ID for forwarding and load-use hazard detection, so it is the consuming end of ID's output bundle and the producing end of ID's forwarding inputs.
- Inserts a bubble whenever ID signals a load-use stall.

Parameters:
- LINK_REG, 31: destination register forced when the latched instruction is jal.
- LINK_OFS, 4: added to the latched pc+4 to form the jal link value (pc+8).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- dwreg, dm2reg, dwmem, daluimm, dshift, djal  in  1 each  decoded controls from ID
- daluc  in  4  ALU op
- da, db, dimm, dpc4  in  32 each  forwarded operands, extended immediate, pc+4
- drn  in  5  destination register
- wpcir  in  1  0 = ID load-use stall, so EXE must take a bubble
- estall  in  1  downstream hold: freeze all stage registers
- ewreg, em2reg, ewmem  out  1 each  latched controls toward MEM and ID
- ern  out  5  effective destination register
- ealu  out  32  ALU / link result (combinational from stage registers)
- eb  out  32  latched store data
- evalid  out  1  stage holds a real instruction
- perf_insn, perf_bubble  out  32 each  see Optional Feature

Behaviour:
- Stage registers: valid, wreg, m2reg, wmem, aluc, aluimm, shift, jal, a, b, imm, rn, pc4.
- Update priority each rising edge:
  - reset: all registers 0. evalid=0, ewreg=0, ewmem=0, em2reg=0, ern=0; ealu equals ADD of zeros = 0.
  - else estall=1: hold every register. wpcir is ignored that cycle; ID is held by the same estall.
  - else wpcir=0: bubble. valid, wreg, m2reg, wmem, jal := 0. Data registers are don't-care; implementation loads them.
  - else: load all d* inputs; valid := 1.
- Outputs:
  - ewreg = wreg & valid; ewmem = wmem & valid; em2reg = m2reg & valid.
  - ern = jal ? LINK_REG : rn; eb = b.
- ALU:
  - Operand A = shift ? {27'b0, imm[10:6]} : a.
  - Operand B = aluimm ? imm : b.
  - aluc[2:0] x000 ADD, x100 SUB, x001 AND, x101 OR, x010 XOR, x110 LUI (B[15:0]<<16), 0011 SLL, 0111 SRL, 1111 SRA (B shifted by A[4:0]).
  - Unlisted codes yield ADD.
  - All arithmetic is 32-bit modulo; no overflow trap.
- ealu = jal ? pc4 + LINK_OFS : ALU result. Combinational, so zero added latency; the result is valid in the cycle after capture.
- Boundaries:
  - Back-to-back bubbles are allowed.
  - A bubble never asserts ewreg, so ID's hazard logic never matches a bubble.
  - SRA by 0 returns B unchanged; shift amounts use only 5 bits.
  - pc4 + LINK_OFS wraps at 2^32.
  - Reset asserted during estall clears the stage (reset wins).

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: two 32-bit wrapping counters, reset to 0, frozen while estall=1.
  - perf_insn increments on each load.
  - perf_bubble increments on each bubble.
- Undefined: counters are not instantiated; perf_insn and perf_bubble are tied to 0.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU op encodings: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA.
  - Register-number width 5, data width 32, LINK_REG default.
- One sub-module, pipe_alu: the purely combinational ALU (a, b, aluc -> r).
- Stage register, bubble logic and counters stay in pipe_exe_stage.

Test Plan:
- Reset, then load add: da=5, db=7, daluc=0000, drn=8, dwreg=1. Next cycle ealu=12, ern=8, ewreg=1, evalid=1.
- Bubble: same inputs with wpcir=0. Next cycle ewreg=0, ewmem=0, em2reg=0, evalid=0; perf_bubble=1 if enabled.
- Hold: load sub (da=3, db=10, ealu=0xFFFFFFF9), then estall=1 for 3 cycles with changing inputs. Outputs stay constant; the 4th cycle with estall=0 loads new values.
- jal: djal=1, dpc4=0x00400004, drn=0. Next cycle ern=31, ealu=0x00400008, ewreg=1.
- Shifts: dshift=1, dimm[10:6]=4, db=0x80000000. SRL gives 0x08000000, SRA gives 0xF8000000, SLL with db=1 gives 0x10.
- Immediate and LUI: daluimm=1, dimm=0x0000ABCD, daluc=x110 gives ealu=0xABCD0000. Reset asserted with estall=1 clears evalid and ewreg next cycle.
